inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache_pkg.sv | 6 +
 rtl/icache_store.sv | 36 +++
 rtl/inst_cache.sv | 77 +++++++
 tb/tb_inst_cache.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared address/instruction widths and the inst_cache FSM encoding.
package inst_cache_pkg;
   localparam int AddressWidth = 32;
   localparam int IDWidth = 32;
   typedef enum logic [1:0] {IDLE, MISS, DROP} icache_state_e;
endpackage

// File: rtl/icache_store.sv
// icache_store: direct-mapped valid/tag/data arrays, combinational read, synchronous write.
module icache_store
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS = 24,
   parameter int DATA_WIDTH = IDWidth
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data
);
   localparam int Lines = 1 << INDEX_BITS;
   logic [Lines-1:0]      valid;
   logic [TAG_BITS-1:0]   tags [Lines];
   logic [DATA_WIDTH-1:0] data [Lines];
   assign rd_valid = valid[rd_idx];
   assign rd_tag = tags[rd_idx];
   assign rd_data = data[rd_idx];
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) valid <= '0;
      else if (wr_en) valid[wr_idx] <= 1'b1;
   // tag/data need no reset: a line is only read through its valid bit
   always_ff @(posedge clk_in)
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped one-word-line instruction cache with blocking miss handling.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_WIDTH = AddressWidth,
   parameter int DATA_WIDTH = IDWidth
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  if_en_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   output logic                  if_rdy_out,
   output logic [DATA_WIDTH-1:0] if_inst_out,
   output logic                  mem_en_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   input  logic                  mem_rdy_in,
   input  logic [DATA_WIDTH-1:0] mem_inst_in
);
   localparam int TagBits = ADDR_WIDTH - INDEX_BITS - 2;
   icache_state_e state, state_nxt;
   logic                  rdy_nxt, rd_valid, hit, fill;
   logic [DATA_WIDTH-1:0] inst_nxt, rd_data;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [TagBits-1:0]    rd_tag;
   icache_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TagBits), .DATA_WIDTH(DATA_WIDTH)) u_store (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_idx  (if_addr_in[INDEX_BITS+1:2]),
      .rd_valid(rd_valid),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .wr_en   (fill && rdy_in),
      .wr_idx  (mem_addr_out[INDEX_BITS+1:2]),
      .wr_tag  (mem_addr_out[ADDR_WIDTH-1:INDEX_BITS+2]),
      .wr_data (mem_inst_in)
   );
   assign hit = rd_valid && rd_tag == if_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
   // request drops in the completion cycle so the controller never starts a second read
   assign mem_en_out = state != IDLE && !mem_rdy_in;
   assign fill = state != IDLE && mem_rdy_in;
   always_comb begin
      state_nxt = state;
      rdy_nxt = 1'b0;
      inst_nxt = if_inst_out;
      addr_nxt = mem_addr_out;
      case (state)
         IDLE:
            if (if_en_in && !flush_in && !if_rdy_out) begin
               state_nxt = hit ? IDLE : MISS;
               rdy_nxt = hit;
               inst_nxt = hit ? rd_data : if_inst_out;
               addr_nxt = hit ? mem_addr_out : if_addr_in;
            end
         MISS: begin
            state_nxt = mem_rdy_in ? IDLE : flush_in ? DROP : MISS;
            rdy_nxt = mem_rdy_in && !flush_in;
            inst_nxt = rdy_nxt ? mem_inst_in : if_inst_out;
         end
         default: state_nxt = mem_rdy_in ? IDLE : DROP;
      endcase
   end
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         state <= IDLE;
         if_rdy_out <= 1'b0;
         if_inst_out <= '0;
         mem_addr_out <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;
         if_rdy_out <= rdy_nxt;
         if_inst_out <= inst_nxt;
         mem_addr_out <= addr_nxt;
      end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed sequence with an expected-instruction scoreboard queue.
module tb_inst_cache;
   logic        clk_in = 0, rst_in = 1, rdy_in = 1, flush_in = 0, if_en_in = 0, mem_rdy_in = 0;
   logic [31:0] if_addr_in = 0, mem_inst_in = 0;
   logic        if_rdy_out, mem_en_out;
   logic [31:0] if_inst_out, mem_addr_out;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk_in = ~clk_in;

   inst_cache dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .flush_in    (flush_in),
      .if_en_in    (if_en_in),
      .if_addr_in  (if_addr_in),
      .if_rdy_out  (if_rdy_out),
      .if_inst_out (if_inst_out),
      .mem_en_out  (mem_en_out),
      .mem_addr_out(mem_addr_out),
      .mem_rdy_in  (mem_rdy_in),
      .mem_inst_in (mem_inst_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pop_chk(input string tag);
      chk({tag, "_rdy"}, 32'(if_rdy_out), 32'd1);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
         n_bad++;
         $error("FAIL %s_q: observed empty scoreboard expected an entry", tag);
      end
      if (exp_q.size() > 0) chk({tag, "_inst"}, if_inst_out, exp_q.pop_front());
   endtask

   task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] word, input int lat);
      if_en_in = 1;
      if_addr_in = addr;
      exp_q.push_back(word);
      cyc();
      if_en_in = 0;
      chk("miss_rdy", 32'(if_rdy_out), 32'd0);
      for (int i = 0; i < lat; i++) begin
         chk("miss_en", 32'(mem_en_out), 32'd1);
         chk("miss_addr", mem_addr_out, addr);
         cyc();
      end
      mem_rdy_in = 1;
      mem_inst_in = word;
      cyc();
      mem_rdy_in = 0;
      pop_chk("fill");
      chk("fill_en_after", 32'(mem_en_out), 32'd0);
      cyc();
      chk("fill_pulse_end", 32'(if_rdy_out), 32'd0);
   endtask

   task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] word);
      if_en_in = 1;
      if_addr_in = addr;
      exp_q.push_back(word);
      cyc();
      if_en_in = 0;
      pop_chk("hit");
      chk("hit_en", 32'(mem_en_out), 32'd0);
      cyc();
      chk("hit_pulse_end", 32'(if_rdy_out), 32'd0);
   endtask

   // the controller never completes while a request is still raised
   always @(negedge clk_in)
      if (mem_rdy_in) chk("hs_en", 32'(mem_en_out), 32'd0);

   initial begin
      #1 rst_in = 0;
      #2;
      chk("rst_rdy", 32'(if_rdy_out), 32'd0);
      chk("rst_inst", if_inst_out, 32'd0);
      chk("rst_addr", mem_addr_out, 32'd0);
      chk("rst_en", 32'(mem_en_out), 32'd0);
      cyc();
      rst_in = 1;
      cyc();
      fetch_miss(32'h100, 32'h00A00093, 3);
      fetch_hit(32'h100, 32'h00A00093);
      fetch_miss(32'h200, 32'h11111111, 2);
      fetch_miss(32'h100, 32'h00A00093, 1);
      if_en_in = 1;
      if_addr_in = 32'h104;
      cyc();
      if_en_in = 0;
      cyc();
      flush_in = 1;
      cyc();
      flush_in = 0;
      chk("drop_en", 32'(mem_en_out), 32'd1);
      chk("drop_addr", mem_addr_out, 32'h104);
      mem_rdy_in = 1;
      mem_inst_in = 32'h22222222;
      cyc();
      mem_rdy_in = 0;
      chk("drop_rdy", 32'(if_rdy_out), 32'd0);
      chk("drop_idle", 32'(mem_en_out), 32'd0);
      fetch_hit(32'h104, 32'h22222222);
      if_en_in = 1;
      if_addr_in = 32'h108;
      cyc();
      if_en_in = 0;
      flush_in = 1;
      mem_rdy_in = 1;
      mem_inst_in = 32'h33333333;
      cyc();
      flush_in = 0;
      mem_rdy_in = 0;
      chk("flushfill_rdy", 32'(if_rdy_out), 32'd0);
      chk("flushfill_idle", 32'(mem_en_out), 32'd0);
      fetch_hit(32'h108, 32'h33333333);
      if_en_in = 1;
      if_addr_in = 32'h100;
      flush_in = 1;
      cyc();
      flush_in = 0;
      if_en_in = 0;
      chk("idleflush_rdy", 32'(if_rdy_out), 32'd0);
      chk("idleflush_en", 32'(mem_en_out), 32'd0);
      if_en_in = 1;
      exp_q.push_back(32'h00A00093);
      cyc();
      pop_chk("busy_first");
      cyc();
      chk("busy_blocked", 32'(if_rdy_out), 32'd0);
      if_en_in = 0;
      cyc();
      fetch_hit(32'h100, 32'h00A00093);
      if_en_in = 1;
      exp_q.push_back(32'h00A00093);
      cyc();
      if_en_in = 0;
      rdy_in = 0;
      pop_chk("frz_hit");
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("frz_rdy", 32'(if_rdy_out), 32'd1);
         chk("frz_inst", if_inst_out, 32'h00A00093);
      end
      rdy_in = 1;
      cyc();
      chk("frz_release", 32'(if_rdy_out), 32'd0);
      if_en_in = 1;
      if_addr_in = 32'h10C;
      exp_q.push_back(32'h44444444);
      cyc();
      if_en_in = 0;
      rdy_in = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("frzmiss_en", 32'(mem_en_out), 32'd1);
         chk("frzmiss_addr", mem_addr_out, 32'h10C);
         chk("frzmiss_rdy", 32'(if_rdy_out), 32'd0);
      end
      rdy_in = 1;
      mem_rdy_in = 1;
      mem_inst_in = 32'h44444444;
      cyc();
      mem_rdy_in = 0;
      pop_chk("frzmiss_fill");
      cyc();
      if_en_in = 1;
      if_addr_in = 32'h300;
      cyc();
      if_en_in = 0;
      chk("rstmiss_en_pre", 32'(mem_en_out), 32'd1);
      #2 rst_in = 0;
      #1;
      chk("rstmiss_en", 32'(mem_en_out), 32'd0);
      chk("rstmiss_addr", mem_addr_out, 32'd0);
      chk("rstmiss_rdy", 32'(if_rdy_out), 32'd0);
      chk("rstmiss_inst", if_inst_out, 32'd0);
      cyc();
      rst_in = 1;
      cyc();
      fetch_miss(32'h100, 32'h00A00093, 1);
      chk("q_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
